sha256_round_engine: RTL and testbench
======================================

# sha256_round_engine

Consumer side of the SHA-256 message-schedule stream: accepts one schedule word W[t] per handshake, runs one compression round per accepted word over working variables a..h, and after the last round adds the result into the chaining value to produce the 256-bit digest. It sits downstream of the W-expansion block and drives the `w_vector_index` it consumes. Blocks are processed one at a time; multi-block messages chain through `hash_in`.

## Interface
- `W_LENGTH`, default 64: rounds per block. Must be 64 for SHA-256; smaller values are for debug only.
- `clock`  in  1  rising-edge clock.
- `reset`  in  1  synchronous, active-high.
- `start`  in  1  begin a block; sampled only in IDLE.
- `first_block`  in  1  at `start`: 1 loads the standard IV as H; 0 loads `hash_in`.
- `hash_in`  in  256  chaining value, {H0..H7}, H0 in [255:224].
- `w_word`  in  32  schedule word W[w_index].
- `w_valid`  in  1  `w_word` is valid for the current `w_index`.
- `w_ready`  out  1  engine accepts a word this cycle.
- `w_index`  out  $clog2(W_LENGTH)  round number t requested from the schedule block.
- `busy`  out  1  state is not IDLE.
- `done`  out  1  single-cycle pulse; `digest` is valid.
- `digest`  out  256  {H0'..H7'}, held until the next `done` or `reset`.

## Operation
- States are IDLE, ROUND, and FINAL.
- IDLE:
  - `start`=1 latches H (IV or `hash_in`) and loads a..h = H0..H7.
  - Sets t=0 and goes to ROUND.
  - `start` in any other state is ignored.
- ROUND:
  - `w_ready`=1 and `w_index`=t.
  - On `w_valid && w_ready`:
    - T1 = h + Σ1(e) + Ch(e,f,g) + K[t] + W.
    - T2 = Σ0(a) + Maj(a,b,c).
    - Shift: h←g, g←f, f←e, e←d+T1, d←c, c←b, b←a, a←T1+T2.
    - t←t+1.
  - Accepting at t=W_LENGTH−1 moves to FINAL.
  - `w_valid`=0 stalls: state and t are held.
- FINAL:
  - `w_ready`=0.
  - `digest` ← {H0+a, …, H7+h}, `done`←1, then IDLE.
- All additions are mod 2^32; carries are discarded.
- Σ0 = ROTR2^ROTR13^ROTR22. Σ1 = ROTR6^ROTR11^ROTR25.
- Ch = (e&f)^(~e&g). Maj = (a&b)^(a&c)^(b&c).
- `w_word` is ignored whenever `w_ready`=0.

## Timing
- Reset values: state IDLE, t=0, `w_ready`=0, `w_index`=0, `busy`=0, `done`=0, `digest`=0, working registers 0.
- `reset` mid-block aborts immediately.
  - Next cycle is IDLE with the reset values above.
  - No `done` pulse is produced for the aborted block.
- `start` high in cycle 0:
  - ROUND and `w_ready`=1 from cycle 1.
  - With `w_valid` held high, words t=0..63 are accepted in cycles 1..64.
  - FINAL in cycle 65; `done`=1 and `digest` valid in cycle 66, with the state back in IDLE.
- Start-to-done latency is 66 cycles plus one per stall cycle.
- `start` in the `done` cycle is accepted; back-to-back blocks run at 66-cycle spacing.
- `w_index` is registered and changes only on an accepted word or on `start`/`reset`.
- `busy` is 1 from cycle 1 through the FINAL cycle inclusive.

## Structure
- `sha256_pkg` holds:
  - the K[0..63] constant array;
  - the IV constants;
  - functions `big_sigma0`, `big_sigma1`, `ch`, `maj`;
  - the state enum.
  - The W-expansion block reuses the package for its small sigma functions, which also belong there.
- Sub-module `sha256_round_step` is purely combinational: a..h, K, W → next a..h.
- The top holds only the FSM, the t counter, the H/digest registers, and the handshake.

## Test plan
- Empty message, `first_block`=1, W0=0x80000000 and W1..W15=0, with the schedule expanded by the reference model:
  - `digest` = e3b0c442 98fc1c14 9afbf4c8 996fb924 27ae41e4 649b934c a495991b 7852b855;
  - `done` at cycle 66.
- "abc": W0=0x61626380, W15=0x00000018, other words as expanded:
  - `digest` = ba7816bf 8f01cfea 414140de 5dae2223 b00361a3 96177a9c b410ff61 f20015ad.
- Two-block "abcdbcdecdefdefgefghfghighijhijkijkljklmjklmnklmnomnopnopq":
  - block 1 with `first_block`=1; block 2 with `first_block`=0 and `hash_in`=block-1 digest;
  - final `digest` = 248d6a61 d20638b8 e5c02693 0c3e6039 a33ce459 64ff2167 f6ecedd4 19db06c1.
- "abc" with `w_valid` deasserted on a random 30% of cycles:
  - same digest as the unstalled run;
  - `done` at cycle 66 + number of stall cycles;
  - `w_index` never skips or repeats an accepted t.
- `reset` asserted at t=20:
  - next cycle is IDLE with `digest`=0 and no `done`;
  - a new "abc" block afterwards yields the correct digest.
- `start` pulsed during ROUND is ignored, with an unchanged result.
- `start` in the `done` cycle begins the next block immediately.

Source files
------------

// File: rtl/sha256_round_engine_pkg.sv
// Shared SHA-256 constants, working-variable type, FSM states and the round/schedule
// boolean functions used by the round engine and the W-expansion block.
package sha256_pkg;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      ROUND = 2'd1,
      FINAL = 2'd2
   } state_t;

   // Working variables; packing order matches {H0..H7}, so a sits in [255:224].
   typedef struct packed {
      logic [31:0] a;
      logic [31:0] b;
      logic [31:0] c;
      logic [31:0] d;
      logic [31:0] e;
      logic [31:0] f;
      logic [31:0] g;
      logic [31:0] h;
   } work_t;

   localparam logic [255:0] IV = {
      32'h6a09e667, 32'hbb67ae85, 32'h3c6ef372, 32'ha54ff53a,
      32'h510e527f, 32'h9b05688c, 32'h1f83d9ab, 32'h5be0cd19
   };

   localparam logic [31:0] K [64] = '{
      32'h428a2f98, 32'h71374491, 32'hb5c0fbcf, 32'he9b5dba5, 32'h3956c25b, 32'h59f111f1, 32'h923f82a4, 32'hab1c5ed5,
      32'hd807aa98, 32'h12835b01, 32'h243185be, 32'h550c7dc3, 32'h72be5d74, 32'h80deb1fe, 32'h9bdc06a7, 32'hc19bf174,
      32'he49b69c1, 32'hefbe4786, 32'h0fc19dc6, 32'h240ca1cc, 32'h2de92c6f, 32'h4a7484aa, 32'h5cb0a9dc, 32'h76f988da,
      32'h983e5152, 32'ha831c66d, 32'hb00327c8, 32'hbf597fc7, 32'hc6e00bf3, 32'hd5a79147, 32'h06ca6351, 32'h14292967,
      32'h27b70a85, 32'h2e1b2138, 32'h4d2c6dfc, 32'h53380d13, 32'h650a7354, 32'h766a0abb, 32'h81c2c92e, 32'h92722c85,
      32'ha2bfe8a1, 32'ha81a664b, 32'hc24b8b70, 32'hc76c51a3, 32'hd192e819, 32'hd6990624, 32'hf40e3585, 32'h106aa070,
      32'h19a4c116, 32'h1e376c08, 32'h2748774c, 32'h34b0bcb5, 32'h391c0cb3, 32'h4ed8aa4a, 32'h5b9cca4f, 32'h682e6ff3,
      32'h748f82ee, 32'h78a5636f, 32'h84c87814, 32'h8cc70208, 32'h90befffa, 32'ha4506ceb, 32'hbef9a3f7, 32'hc67178f2
   };

   function automatic logic [31:0] rotr(input logic [31:0] x, input int n);
      return (x >> n) | (x << (32 - n));
   endfunction

   function automatic logic [31:0] big_sigma0(input logic [31:0] x);
      return rotr(x, 2) ^ rotr(x, 13) ^ rotr(x, 22);
   endfunction

   function automatic logic [31:0] big_sigma1(input logic [31:0] x);
      return rotr(x, 6) ^ rotr(x, 11) ^ rotr(x, 25);
   endfunction

   function automatic logic [31:0] small_sigma0(input logic [31:0] x);
      return rotr(x, 7) ^ rotr(x, 18) ^ (x >> 3);
   endfunction

   function automatic logic [31:0] small_sigma1(input logic [31:0] x);
      return rotr(x, 17) ^ rotr(x, 19) ^ (x >> 10);
   endfunction

   function automatic logic [31:0] ch(input logic [31:0] e, input logic [31:0] f, input logic [31:0] g);
      return (e & f) ^ (~e & g);
   endfunction

   function automatic logic [31:0] maj(input logic [31:0] a, input logic [31:0] b, input logic [31:0] c);
      return (a & b) ^ (a & c) ^ (b & c);
   endfunction

endpackage

// File: rtl/sha256_round_engine_if.sv
// Control, chaining-value and schedule-stream bundle between a block driver and the round engine.
interface sha256_round_engine_if #(
   parameter int W_LENGTH = 64
);
   localparam int IW = (W_LENGTH > 1) ? $clog2(W_LENGTH) : 1;

   logic          start;
   logic          first_block;
   logic [255:0]  hash_in;
   logic [31:0]   w_word;
   logic          w_valid;
   logic          w_ready;
   logic [IW-1:0] w_index;
   logic          busy;
   logic          done;
   logic [255:0]  digest;

   modport master (
      output start, first_block, hash_in, w_word, w_valid,
      input  w_ready, w_index, busy, done, digest
   );

   modport slave (
      input  start, first_block, hash_in, w_word, w_valid,
      output w_ready, w_index, busy, done, digest
   );
endinterface

// File: rtl/sha256_round_step.sv
// One SHA-256 compression round, purely combinational: current a..h, K[t], W[t] -> next a..h.
module sha256_round_step
   import sha256_pkg::*;
(
   input  work_t       cur,
   input  logic [31:0] k,
   input  logic [31:0] w,
   output work_t       nxt
);
   logic [31:0] t1;
   logic [31:0] t2;

   always_comb begin
      t1 = cur.h + big_sigma1(cur.e) + ch(cur.e, cur.f, cur.g) + k + w;
      t2 = big_sigma0(cur.a) + maj(cur.a, cur.b, cur.c);
      nxt.h = cur.g;
      nxt.g = cur.f;
      nxt.f = cur.e;
      nxt.e = cur.d + t1;
      nxt.d = cur.c;
      nxt.c = cur.b;
      nxt.b = cur.a;
      nxt.a = t1 + t2;
   end
endmodule

// File: rtl/sha256_round_engine.sv
// SHA-256 block engine: consumes W[t] over a ready/valid stream, one round per accepted word,
// then folds the working variables into the chaining value and pulses done with the digest.
module sha256_round_engine
   import sha256_pkg::*;
#(
   parameter int W_LENGTH = 64
) (
   input logic                  clock,
   input logic                  reset,
   sha256_round_engine_if.slave bus
);
   localparam int IW = (W_LENGTH > 1) ? $clog2(W_LENGTH) : 1;

   state_t        state_reg;
   logic [IW-1:0] t_reg;
   logic [255:0]  h_reg;
   work_t         work_reg;
   work_t         work_next;
   logic          done_reg;
   logic [255:0]  digest_reg;
   logic [255:0]  final_sum;

   sha256_round_step u_step (
      .cur (work_reg),
      .k   (K[t_reg]),
      .w   (bus.w_word),
      .nxt (work_next)
   );

   // Per-word mod 2^32 feed-forward of the working variables into H.
   for (genvar gi = 0; gi < 8; gi++) begin : g_final_add
      assign final_sum[gi*32 +: 32] = h_reg[gi*32 +: 32] + work_reg[gi*32 +: 32];
   end

   always_ff @(posedge clock) begin
      if (reset) begin
         state_reg  <= IDLE;
         t_reg      <= '0;
         h_reg      <= '0;
         work_reg   <= '0;
         done_reg   <= 1'b0;
         digest_reg <= '0;
      end else begin
         done_reg <= 1'b0;
         case (state_reg)
            IDLE: begin
               if (bus.start) begin
                  h_reg     <= bus.first_block ? IV : bus.hash_in;
                  work_reg  <= bus.first_block ? IV : bus.hash_in;
                  t_reg     <= '0;
                  state_reg <= ROUND;
               end
            end
            ROUND: begin
               if (bus.w_valid) begin
                  work_reg <= work_next;
                  if (t_reg == IW'(W_LENGTH - 1)) begin
                     t_reg     <= '0;
                     state_reg <= FINAL;
                  end else begin
                     t_reg <= t_reg + IW'(1);
                  end
               end
            end
            FINAL: begin
               digest_reg <= final_sum;
               done_reg   <= 1'b1;
               state_reg  <= IDLE;
            end
            default: state_reg <= IDLE;
         endcase
      end
   end

   assign bus.w_ready = (state_reg == ROUND);
   assign bus.w_index = t_reg;
   assign bus.busy    = (state_reg != IDLE);
   assign bus.done    = done_reg;
   assign bus.digest  = digest_reg;
endmodule

// File: tb/tb_sha256_round_engine.sv
// Directed bench for sha256_round_engine: known-answer digests, latency, stalls, abort and restart.
module tb_sha256_round_engine;

   logic clock = 1'b0;
   logic reset = 1'b1;

   always #5 clock = ~clock;

   sha256_round_engine_if #(.W_LENGTH(64)) eng ();

   sha256_round_engine #(.W_LENGTH(64)) dut (
      .clock (clock),
      .reset (reset),
      .bus   (eng)
   );

   localparam logic [255:0] DIG_EMPTY = 256'he3b0c442_98fc1c14_9afbf4c8_996fb924_27ae41e4_649b934c_a495991b_7852b855;
   localparam logic [255:0] DIG_ABC   = 256'hba7816bf_8f01cfea_414140de_5dae2223_b00361a3_96177a9c_b410ff61_f20015ad;
   localparam logic [255:0] DIG_TWO   = 256'h248d6a61_d20638b8_e5c02693_0c3e6039_a33ce459_64ff2167_f6ecedd4_19db06c1;

   int n_checks = 0;
   int n_pass   = 0;
   int idx_err  = 0;

   logic [31:0]  msg [16];
   logic [255:0] last_digest;
   int           last_cyc;
   int           last_stalls;
   bit           last_aborted;

   task automatic chk(input string tag, input logic [255:0] got, input logic [255:0] exp);
      n_checks++;
      if (got !== exp)
         $display("FAIL %s: got %h expected %h", tag, got, exp);
      else
         n_pass++;
   endtask

   function automatic logic [31:0] rr(input logic [31:0] x, input int n);
      return (x >> n) | (x << (32 - n));
   endfunction

   task automatic load_empty();
      msg = '{default: 32'h0};
      msg[0] = 32'h80000000;
   endtask

   task automatic load_abc();
      msg = '{default: 32'h0};
      msg[0]  = 32'h61626380;
      msg[15] = 32'h00000018;
   endtask

   // Acts as the schedule block; caller must be at a negedge. Returns at the negedge where done is seen.
   task automatic run_block(input bit first, input logic [255:0] hin, input int stall_pct,
                            input int abort_at, input int pulse_at);
      logic [31:0] w [64];
      int acc;
      bit fin;
      bit pulsed;
      for (int i = 0; i < 16; i++) w[i] = msg[i];
      for (int i = 16; i < 64; i++)
         w[i] = (rr(w[i-2], 17) ^ rr(w[i-2], 19) ^ (w[i-2] >> 10)) + w[i-7]
              + (rr(w[i-15], 7) ^ rr(w[i-15], 18) ^ (w[i-15] >> 3)) + w[i-16];
      eng.start       = 1'b1;
      eng.first_block = first;
      eng.hash_in     = hin;
      eng.w_valid     = 1'b0;
      last_cyc     = 0;
      last_stalls  = 0;
      last_aborted = 1'b0;
      acc    = 0;
      fin    = 1'b0;
      pulsed = 1'b0;
      @(posedge clock);
      while (!fin && last_cyc < 400) begin
         @(negedge clock);
         last_cyc++;
         eng.start   = 1'b0;
         eng.w_valid = 1'b0;
         if (last_cyc == 1) chk("busy_cycle1", 256'(eng.busy), 256'(1));
         if (eng.done) begin
            last_digest = eng.digest;
            fin = 1'b1;
            chk("busy_in_done_cycle", 256'(eng.busy), 256'(0));
            $display("block: cycles=%0d stalls=%0d digest=%h", last_cyc, last_stalls, last_digest);
         end else if (eng.w_ready) begin
            if (abort_at >= 0 && int'(eng.w_index) == abort_at) begin
               reset = 1'b1;
               last_aborted = 1'b1;
               fin = 1'b1;
               $display("block: aborted at t=%0d", abort_at);
            end else begin
               if (pulse_at >= 0 && !pulsed && int'(eng.w_index) == pulse_at) begin
                  eng.start       = 1'b1;
                  eng.first_block = 1'b0;
                  eng.hash_in     = {8{$urandom}};
                  pulsed = 1'b1;
               end
               if (int'($urandom_range(99, 0)) < stall_pct) begin
                  last_stalls++;
               end else begin
                  if (int'(eng.w_index) != acc) idx_err++;
                  eng.w_valid = 1'b1;
                  eng.w_word  = w[eng.w_index];
                  acc++;
               end
            end
         end
      end
      chk("no_timeout", 256'(fin), 256'(1));
   endtask

   initial begin
      logic [255:0] saved;
      int seen;
      eng.start       = 1'b0;
      eng.first_block = 1'b0;
      eng.hash_in     = '0;
      eng.w_word      = '0;
      eng.w_valid     = 1'b0;
      repeat (3) @(negedge clock);
      chk("rst_busy",    256'(eng.busy),    256'(0));
      chk("rst_w_ready", 256'(eng.w_ready), 256'(0));
      chk("rst_w_index", 256'(eng.w_index), 256'(0));
      chk("rst_done",    256'(eng.done),    256'(0));
      chk("rst_digest",  eng.digest,        256'(0));
      reset = 1'b0;
      repeat (2) @(negedge clock);

      load_empty();
      run_block(1'b1, '0, 0, -1, -1);
      chk("empty_digest", last_digest, DIG_EMPTY);
      chk("empty_latency", 256'(last_cyc), 256'(66));
      @(negedge clock);
      chk("done_single_pulse", 256'(eng.done), 256'(0));
      chk("digest_held", eng.digest, DIG_EMPTY);

      load_abc();
      run_block(1'b1, '0, 0, -1, -1);
      chk("abc_digest", last_digest, DIG_ABC);

      msg = '{32'h61626364, 32'h62636465, 32'h63646566, 32'h64656667,
              32'h65666768, 32'h66676869, 32'h6768696a, 32'h68696a6b,
              32'h696a6b6c, 32'h6a6b6c6d, 32'h6b6c6d6e, 32'h6c6d6e6f,
              32'h6d6e6f70, 32'h6e6f7071, 32'h80000000, 32'h00000000};
      @(negedge clock);
      run_block(1'b1, '0, 0, -1, -1);
      saved = last_digest;
      msg = '{default: 32'h0};
      msg[15] = 32'h000001c0;
      repeat (3) @(negedge clock);
      run_block(1'b0, saved, 0, -1, -1);
      chk("two_block_digest", last_digest, DIG_TWO);

      load_abc();
      idx_err = 0;
      @(negedge clock);
      run_block(1'b1, '0, 30, -1, -1);
      chk("stall_digest", last_digest, DIG_ABC);
      chk("stall_latency", 256'(last_cyc), 256'(66 + last_stalls));
      chk("stall_index_order", 256'(idx_err), 256'(0));

      @(negedge clock);
      run_block(1'b1, '0, 0, 20, -1);
      chk("abort_taken", 256'(last_aborted), 256'(1));
      @(negedge clock);
      chk("abort_busy",    256'(eng.busy),    256'(0));
      chk("abort_w_ready", 256'(eng.w_ready), 256'(0));
      chk("abort_w_index", 256'(eng.w_index), 256'(0));
      chk("abort_done",    256'(eng.done),    256'(0));
      chk("abort_digest",  eng.digest,        256'(0));
      reset = 1'b0;
      seen = 0;
      repeat (70) begin
         @(negedge clock);
         if (eng.done) seen++;
      end
      chk("abort_no_done", 256'(seen), 256'(0));
      run_block(1'b1, '0, 0, -1, -1);
      chk("after_abort_digest", last_digest, DIG_ABC);

      @(negedge clock);
      run_block(1'b1, '0, 0, -1, 30);
      chk("start_in_round_digest", last_digest, DIG_ABC);
      chk("start_in_round_latency", 256'(last_cyc), 256'(66));

      load_empty();
      @(negedge clock);
      run_block(1'b1, '0, 0, -1, -1);
      saved = last_digest;
      load_abc();
      run_block(1'b1, '0, 0, -1, -1);
      chk("b2b_first_digest", saved, DIG_EMPTY);
      chk("b2b_second_digest", last_digest, DIG_ABC);
      chk("b2b_spacing", 256'(last_cyc), 256'(66));

      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule
